score_counter: RTL
==================

Name: score_counter

Overview:
- Upstream neighbour of the game clock divider. Accumulates the player score as four BCD digits and drives the ones/tens/hundreds/thousands digit inputs that select the fall speed.
- Consumes line-clear events from the board logic over a valid/ready handshake.
- Adds points serially, one digit per cycle, into a shadow accumulator.
- Commits all four digits in one cycle, so downstream logic never sees a partial sum.

Parameters:
- PTS_1, 1, points for a 1-line clear (BCD digit, 0..9)
- PTS_2, 3, points for a 2-line clear (0..9)
- PTS_3, 5, points for a 3-line clear (0..9)
- PTS_4, 8, points for a 4-line clear (0..9)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- score_clr  in  1  synchronous new-game clear; highest priority after reset
- clear_valid  in  1  line-clear event present
- clear_lines  in  3  number of lines cleared with the event (legal 1..4)
- clear_ready  out  1  block can accept an event this cycle
- score1  out  4  ones digit (BCD)
- score2  out  4  tens digit
- score3  out  4  hundreds digit
- score4  out  4  thousands digit
- score_updated  out  1  one-cycle pulse when new digits are committed
- score_sat  out  1  sticky: score has saturated at 9999

Behaviour:
- Reset (rst low, async):
  - score1..4 = 0, score_updated = 0, score_sat = 0.
  - FSM = IDLE; accumulator and addend cleared.
- States:
  - IDLE: clear_ready = 1 unless score_clr = 1.
  - ADD: digit index 0..3.
  - COMMIT.
- Accept: clear_valid && clear_ready at edge T.
  - Latch addend = PTS_n for clear_lines n.
  - Copy committed digits into the working accumulator.
  - Carry = 0, idx = 0, go to ADD.
- clear_lines = 0 or 5..7: event is accepted with addend 0. Digits are unchanged, but score_updated still pulses.
- ADD, edges T+1..T+4: working digit[idx] = BCD sum of digit[idx] + (idx==0 ? addend : 0) + carry.
  - A sum of 10 or more yields (sum-10) and carry = 1.
  - idx increments. After idx 3, go to COMMIT.
- COMMIT, edge T+5:
  - If carry out of the thousands digit is 1: score1..4 = 9,9,9,9 and score_sat = 1.
  - Otherwise score1..4 = working digits.
  - score_updated = 1 for exactly this one cycle. Go to IDLE.
- Latency: new digits visible on outputs 5 cycles after the accept edge. clear_ready is low from T+1 through T+5 and high again after the COMMIT edge.
- Once score_sat = 1, further events are still accepted, digits stay at 9999, and score_updated still pulses.
- clear_valid while not ready: ignored. The producer must hold valid until ready; no queuing.
- score_clr = 1, any state:
  - Next edge: FSM = IDLE, score1..4 = 0, score_sat = 0, score_updated = 0.
  - Any in-flight addition is aborted and discarded.
  - clear_ready = 0 in that cycle, so a simultaneous event is not accepted.
- Async reset mid-addition: immediate return to reset values; nothing is committed.
- Outputs are registered. score1..4 change only on the COMMIT edge, score_clr, or reset.

Decomposition:
- Package score_pkg:
  - State enum (IDLE, ADD, COMMIT).
  - BCD digit width (4) and max digit value 9.
  - Default point constants.
- Sub-module bcd_digit_add, combinational:
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: sum[3:0], cout.
  - Instantiated once and reused serially per digit.

Test Plan:
- Reset, then one event clear_lines=4 at edge T → score1..4 = 8,0,0,0 at T+5; score_updated high for exactly one cycle; clear_ready low T+1..T+5.
- Starting from 0,0,0,0: events 4,3,3 (8+5+5) → 8,0,0,0 → 3,1,0,0 → 8,1,0,0. The carry from ones into tens is checked.
- Preload 9,9,9,9 minus 1 (8,9,9,9) and send clear_lines=2 (+3) → 9,9,9,9 with score_sat = 1. A further event keeps 9,9,9,9 and still pulses score_updated.
- Starting from 7,9,9,0: send clear_lines=1 → 8,9,9,0. Then clear_lines=2 (+3) → 1,0,0,1, a ripple carry through all digits.
- Assert score_clr at T+2 of an in-flight addition with score 5,2,0,0 → 0,0,0,0 next edge; no score_updated; an event held simultaneously with score_clr is not accepted that cycle.
- Drop rst low at T+3 mid-addition → all outputs 0 immediately (asynchronously); after rst rises, accept a clear_lines=1 event → 1,0,0,0.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score counter.
package score_pkg;

   localparam int             NUM_DIG = 4;
   localparam int             DIG_W   = 4;
   localparam logic [DIG_W-1:0] DIG_MAX = 4'd9;

   localparam logic [DIG_W-1:0] PTS_1_DEF = 4'd1;
   localparam logic [DIG_W-1:0] PTS_2_DEF = 4'd3;
   localparam logic [DIG_W-1:0] PTS_3_DEF = 4'd5;
   localparam logic [DIG_W-1:0] PTS_4_DEF = 4'd8;

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_COMMIT} state_e;

   // Digit 0 is the ones digit.
   typedef logic [NUM_DIG-1:0][DIG_W-1:0] bcd_t;

   // Illegal line counts score nothing but still go through a full commit.
   function automatic logic [DIG_W-1:0] lines_to_pts(
      input logic [2:0]       n,
      input logic [DIG_W-1:0] p1,
      input logic [DIG_W-1:0] p2,
      input logic [DIG_W-1:0] p3,
      input logic [DIG_W-1:0] p4
   );
      case (n)
         3'd1:    return p1;
         3'd2:    return p2;
         3'd3:    return p3;
         3'd4:    return p4;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/score_counter_if.sv
// Line-clear event handshake from the board logic.
interface score_counter_if;

   logic       clear_valid;
   logic [2:0] clear_lines;
   logic       clear_ready;

   modport master (output clear_valid, output clear_lines, input  clear_ready);
   modport slave  (input  clear_valid, input  clear_lines, output clear_ready);

endinterface

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with carry in/out; reused serially across digits.
module bcd_digit_add
   import score_pkg::*;
(
   input  logic [DIG_W-1:0] a,
   input  logic [DIG_W-1:0] b,
   input  logic             cin,
   output logic [DIG_W-1:0] sum,
   output logic             cout
);

   logic [DIG_W:0] raw;

   assign raw  = {1'b0, a} + {1'b0, b} + {{DIG_W{1'b0}}, cin};
   assign cout = (raw >= 5'd10);
   assign sum  = cout ? 4'(raw - 5'd10) : raw[DIG_W-1:0];

endmodule

// File: rtl/score_counter.sv
// Four-digit BCD score: serial digit-by-digit add into a shadow copy, then
// an atomic commit so downstream never sees a partial sum.
module score_counter
   import score_pkg::*;
#(
   parameter logic [DIG_W-1:0] PTS_1 = PTS_1_DEF,
   parameter logic [DIG_W-1:0] PTS_2 = PTS_2_DEF,
   parameter logic [DIG_W-1:0] PTS_3 = PTS_3_DEF,
   parameter logic [DIG_W-1:0] PTS_4 = PTS_4_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             score_clr,
   score_counter_if.slave   clr_if,
   output logic [DIG_W-1:0] score1,
   output logic [DIG_W-1:0] score2,
   output logic [DIG_W-1:0] score3,
   output logic [DIG_W-1:0] score4,
   output logic             score_updated,
   output logic             score_sat
);

   state_e           state_q;
   logic [1:0]       idx_q;
   logic             carry_q;
   logic [DIG_W-1:0] addend_q;
   bcd_t             acc_q;
   bcd_t             score_q;
   logic             upd_q;
   logic             sat_q;

   logic [DIG_W-1:0] dig_a, dig_b, sum_d;
   logic             carry_d;

   assign dig_a = acc_q[idx_q];
   assign dig_b = (idx_q == 2'd0) ? addend_q : '0;

   bcd_digit_add u_add (
      .a    (dig_a),
      .b    (dig_b),
      .cin  (carry_q),
      .sum  (sum_d),
      .cout (carry_d)
   );

   // New-game clear wins over a simultaneous event.
   assign clr_if.clear_ready = (state_q == S_IDLE) && !score_clr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         addend_q <= '0;
         acc_q    <= '0;
         score_q  <= '0;
         upd_q    <= 1'b0;
         sat_q    <= 1'b0;
      end else if (score_clr) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         addend_q <= '0;
         acc_q    <= '0;
         score_q  <= '0;
         upd_q    <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         upd_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (clr_if.clear_valid && clr_if.clear_ready) begin
                  addend_q <= lines_to_pts(clr_if.clear_lines, PTS_1, PTS_2, PTS_3, PTS_4);
                  acc_q    <= score_q;
                  carry_q  <= 1'b0;
                  idx_q    <= '0;
                  state_q  <= S_ADD;
               end
            end
            S_ADD: begin
               acc_q[idx_q] <= sum_d;
               carry_q      <= carry_d;
               idx_q        <= idx_q + 2'd1;
               if (idx_q == 2'(NUM_DIG - 1)) state_q <= S_COMMIT;
            end
            S_COMMIT: begin
               // Carry out of the thousands digit pins the score at 9999.
               if (carry_q) begin
                  score_q <= {NUM_DIG{DIG_MAX}};
                  sat_q   <= 1'b1;
               end else begin
                  score_q <= acc_q;
               end
               upd_q   <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign score1        = score_q[0];
   assign score2        = score_q[1];
   assign score3        = score_q[2];
   assign score4        = score_q[3];
   assign score_updated = upd_q;
   assign score_sat     = sat_q;

endmodule
